seq_restoring_divider: RTL and testbench

- Sequential radix-2 restoring divider; the inverse of the team's 4-bit combinational array multiplier.
- Takes a 2N-bit dividend (a product word) and an N-bit divisor. Returns an N-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Used in the multiplier verification loop to recover operands, and as a standalone arithmetic unit behind a valid/ready handshake.

---
 rtl/seq_restoring_divider_if.sv | 21 ++
 rtl/seq_restoring_divider.sv | 104 ++++++++++
 tb/tb_seq_restoring_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand/result handshake bundle for the restoring divider
interface seq_restoring_divider_if #(parameter int N = 4);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: radix-2 restoring divider, 2N/N -> N quotient and N remainder, one bit per cycle
module seq_restoring_divider #(
  parameter int N = 4
) (
  input logic                   clk,
  input logic                   rst,
  seq_restoring_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  state_t         state_q;
  logic [2*N-1:0] d_q;
  logic [N-1:0]   v_q;
  logic [N-1:0]   r_q;
  logic [N-1:0]   q_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   quo_q;
  logic [N-1:0]   rem_q;
  logic           dbz_q;
  logic           ovf_q;
  logic [N:0]     t_d;
  logic           ge_d;
  logic [N-1:0]   r_d;
  logic [N-1:0]   q_d;
  logic [N-1:0]   hi_d;
  assign hi_d = d_q[2*N-1:N];
  // r_q < v_q always holds, so its top bit is implicitly zero and need not be stored
  always_comb begin
    t_d  = {r_q, d_q[cnt_q]};
    ge_d = t_d >= {1'b0, v_q};
    r_d  = ge_d ? N'(t_d - {1'b0, v_q}) : t_d[N-1:0];
    q_d  = q_q | (N'(ge_d) << cnt_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      v_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          d_q        <= bus.dividend;
          v_q        <= bus.divisor;
          in_ready_q <= 1'b0;
          state_q    <= CHECK;
        end
        CHECK: begin
          dbz_q <= v_q == '0;
          ovf_q <= v_q != '0 && hi_d >= v_q;
          if (v_q == '0) begin
            quo_q   <= '1;
            rem_q   <= d_q[N-1:0];
            state_q <= DONE;
          end else if (hi_d >= v_q) begin
            quo_q   <= '1;
            rem_q   <= '0;
            state_q <= DONE;
          end else begin
            r_q     <= hi_d;
            q_q     <= '0;
            cnt_q   <= CW'(N - 1);
            state_q <= ITER;
          end
        end
        ITER: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: if (!out_valid_q) begin
          out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors, corner sequences and a full 8/4-bit sweep of the divider
module tb_seq_restoring_divider;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_restoring_divider_if #(.N(N)) bus();
  seq_restoring_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;
  vec_t vecs[9];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv, input bit early, input int hold,
                        input bit poke, output logic [3:0] q, output logic [3:0] r,
                        output logic dbz, output logic ovf, output int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor = dv;
    bus.out_ready = early;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    dbz = bus.div_by_zero;
    ovf = bus.overflow;
    if (!early) repeat (hold) begin
      @(negedge clk);
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.dividend = 8'h55;
        bus.divisor = 4'd3;
      end
      @(posedge clk);
      #1 check("hold stable",
               32'({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}),
               32'({1'b1, 1'b0, q, r, dbz, ovf}));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("out_valid drop", 32'(bus.out_valid), 32'd0);
    check("in_ready after accept", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [3:0] q, r, eq, er;
    logic       dbz, ovf, edbz, eovf;
    int         lat;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    vecs[0] = '{8'd200, 4'd13, 4'd15, 4'd5,  1'b0, 1'b0, 6};
    vecs[1] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 6};
    vecs[2] = '{8'd0,   4'd5,  4'd0,  4'd0,  1'b0, 1'b0, 6};
    vecs[3] = '{8'd255, 4'd15, 4'd15, 4'd0,  1'b0, 1'b1, 2};
    vecs[4] = '{8'd9,   4'd0,  4'd15, 4'd9,  1'b1, 1'b0, 2};
    vecs[5] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 6};
    vecs[6] = '{8'd16,  4'd1,  4'd15, 4'd0,  1'b0, 1'b1, 2};
    vecs[7] = '{8'd15,  4'd1,  4'd15, 4'd0,  1'b0, 1'b0, 6};
    vecs[8] = '{8'd143, 4'd11, 4'd13, 4'd0,  1'b0, 1'b0, 6};
    #12;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset outputs",
          32'({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, i == 0, 0, 1'b0, q, r, dbz, ovf, lat);
      check($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d flags", i), 32'({dbz, ovf}), 32'({vecs[i].dbz, vecs[i].ovf}));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end
    // divide-by-zero result held under back-pressure while a new operand is offered
    run_op(8'd9, 4'd0, 1'b0, 5, 1'b1, q, r, dbz, ovf, lat);
    check("dbz hold result", 32'({q, r, dbz, ovf}), 32'({4'd15, 4'd9, 1'b1, 1'b0}));
    check("dbz hold latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("poke ignored in_ready", 32'(bus.in_ready), 32'd1);
    // asynchronous reset in the middle of the iteration phase
    bus.in_valid = 1'b1;
    bus.dividend = 8'd143;
    bus.divisor = 4'd11;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async reset in_ready", 32'(bus.in_ready), 32'd1);
    check("async reset outputs",
          32'({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}), 32'd0);
    #2 rst = 1'b0;
    run_op(8'd143, 4'd11, 1'b0, 0, 1'b0, q, r, dbz, ovf, lat);
    check("post-reset result", 32'({q, r, dbz, ovf}), 32'({4'd13, 4'd0, 1'b0, 1'b0}));
    check("post-reset latency", 32'(lat), 32'd6);
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        edbz = dv == 0;
        eovf = dv != 0 && (dd >> 4) >= dv;
        eq = (edbz || eovf) ? 4'd15 : 4'(dd / dv);
        er = edbz ? 4'(dd) : eovf ? 4'd0 : 4'(dd % dv);
        run_op(8'(dd), 4'(dv), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0,
               q, r, dbz, ovf, lat);
        check($sformatf("sweep %0d/%0d", dd, dv), 32'({q, r, dbz, ovf}), 32'({eq, er, edbz, eovf}));
        check($sformatf("sweep %0d/%0d latency", dd, dv), 32'(lat), (edbz || eovf) ? 32'd2 : 32'd6);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
